// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle controller: FSM state
// encoding, RV32 base opcodes and ALU operation codes.
package multicycle_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALU_OP_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [OPCODE_W-1:0] OPC_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// opcode_class: combinational opcode classifier shared by DECODE and EXEC.
// Ports:
//   i_opcode     instr[6:0]
//   o_is_r       R-type ALU
//   o_is_i       I-type ALU
//   o_is_load    load
//   o_is_store   store
//   o_is_branch  conditional branch
//   o_is_legal   any of the above
module opcode_class
  import multicycle_pkg::*;
(
  input  logic [OPCODE_W-1:0] i_opcode,
  output logic                o_is_r,
  output logic                o_is_i,
  output logic                o_is_load,
  output logic                o_is_store,
  output logic                o_is_branch,
  output logic                o_is_legal
);

  assign o_is_r      = (i_opcode == OPC_R);
  assign o_is_i      = (i_opcode == OPC_I_ALU);
  assign o_is_load   = (i_opcode == OPC_LOAD);
  assign o_is_store  = (i_opcode == OPC_STORE);
  assign o_is_branch = (i_opcode == OPC_BRANCH);
  assign o_is_legal  = o_is_r | o_is_i | o_is_load | o_is_store | o_is_branch;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM for a multicycle
// RV32 datapath, with a retired-instruction counter.
// Optional build macro: MULTICYCLE_ILLEGAL_TRAP_EN (unknown opcodes lock the
// FSM in TRAP with illegal_instr=1; otherwise they are dropped as NOPs).
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   opcode              instr[6:0] from the IR
//   zero                ALU zero flag (branch condition in EXEC)
//   mem_ready           memory handshake, honoured in FETCH and MEM
//   pc_write .. alusrc  datapath controls, decoded from state and opcode
//   illegal_instr       high while trapped
//   alu_op              00 add, 01 sub, 10 funct-decoded
//   state               current FSM state
//   retired             completed-instruction count (wraps)
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_src,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                alusrc,
  output logic                illegal_instr,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [STATE_W-1:0]  state,
  output logic [RETIRE_W-1:0] retired
);

  state_e              r_state;
  logic [RETIRE_W-1:0] r_retired;

  logic w_is_r, w_is_i, w_is_load, w_is_store, w_is_branch, w_is_legal;

  opcode_class u_opcode_class (
    .i_opcode    (opcode),
    .o_is_r      (w_is_r),
    .o_is_i      (w_is_i),
    .o_is_load   (w_is_load),
    .o_is_store  (w_is_store),
    .o_is_branch (w_is_branch),
    .o_is_legal  (w_is_legal)
  );

  // State register and retire counter; retirement is counted on the edge
  // that leaves the instruction's final state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_ready) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (w_is_legal) begin
            r_state <= ST_EXEC;
          end else begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
            r_state <= ST_TRAP;
`else
            r_state <= ST_FETCH;
`endif
          end
        end
        ST_EXEC: begin
          if (w_is_r || w_is_i) begin
            r_state <= ST_WB;
          end else if (w_is_load || w_is_store) begin
            r_state <= ST_MEM;
          end else begin
            r_state <= ST_FETCH;
            if (w_is_branch) r_retired <= r_retired + RETIRE_W'(1);
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (w_is_store) begin
              r_state   <= ST_FETCH;
              r_retired <= r_retired + RETIRE_W'(1);
            end else begin
              r_state <= ST_WB;
            end
          end
        end
        ST_WB: begin
          r_state   <= ST_FETCH;
          r_retired <= r_retired + RETIRE_W'(1);
        end
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Control decode; everything is forced low while reset is held so an
  // in-flight write is cut off in the same cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alusrc        = 1'b0;
    illegal_instr = 1'b0;
    alu_op        = ALU_ADD;
    if (rst_n) begin
      case (r_state)
        ST_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        ST_EXEC: begin
          alusrc = w_is_i | w_is_load | w_is_store;
          if (w_is_load || w_is_store) alu_op = ALU_ADD;
          else if (w_is_branch)        alu_op = ALU_SUB;
          else                         alu_op = ALU_FUNCT;
          if (w_is_branch) begin
            pc_src   = 1'b1;
            pc_write = zero;
          end
        end
        ST_MEM: begin
          // Load and store classes are exclusive, so read/write never overlap.
          mem_read  = w_is_load;
          mem_write = w_is_store;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = w_is_load;
        end
        ST_TRAP: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          illegal_instr = 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign state   = STATE_W'(r_state);
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (RETIRE_W=4 so the wrap is reachable).
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_src, ir_write, mem_read, mem_write;
  logic       reg_write, mem_to_reg, alusrc, illegal_instr;
  logic [1:0] alu_op;
  logic [2:0] state;
  logic [3:0] retired;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] exp_ret;

  multicycle_ctrl #(.RETIRE_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .ir_write      (ir_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .alusrc        (alusrc),
    .illegal_instr (illegal_instr),
    .alu_op        (alu_op),
    .state         (state),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; opcode = 7'b0110011; mem_ready = 1'b1; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_tests++; if (retired !== 4'd0) begin n_fail++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    n_tests++;
    if ({pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alusrc, illegal_instr} !== 9'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000000",
        {pc_write, pc_src, ir_write, mem_read, mem_write, reg_write, mem_to_reg, alusrc, illegal_instr});
    end
    n_tests++; if (alu_op !== 2'b00) begin n_fail++; $display("FAIL reset_alu_op: got %b expected 00", alu_op); end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if ({mem_read, ir_write, pc_write, pc_src} !== 4'b1110) begin
      n_fail++; $display("FAIL fetch_release: got %b expected 1110", {mem_read, ir_write, pc_write, pc_src});
    end
    exp_ret = 4'd0;
  endtask

  task automatic test_rtype;
    opcode = 7'b0110011; mem_ready = 1'b1;
    step;
    n_tests++; if (state !== 3'd1) begin n_fail++; $display("FAIL r_decode_state: got %0d expected 1", state); end
    step;
    n_tests++;
    if ({state, alusrc, alu_op, pc_write} !== {3'd2, 1'b0, 2'b10, 1'b0}) begin
      n_fail++; $display("FAIL r_exec: got st=%0d alusrc=%b alu_op=%b pcw=%b expected st=2 alusrc=0 alu_op=10 pcw=0",
        state, alusrc, alu_op, pc_write);
    end
    step;
    n_tests++;
    if ({state, reg_write, mem_to_reg, retired} !== {3'd4, 1'b1, 1'b0, exp_ret}) begin
      n_fail++; $display("FAIL r_wb: got st=%0d rw=%b m2r=%b ret=%0d expected st=4 rw=1 m2r=0 ret=%0d",
        state, reg_write, mem_to_reg, retired, exp_ret);
    end
    step;
    exp_ret = exp_ret + 4'd1;
    n_tests++;
    if ({state, retired} !== {3'd0, exp_ret}) begin
      n_fail++; $display("FAIL r_retire: got st=%0d ret=%0d expected st=0 ret=%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_store;
    opcode = 7'b0100011; mem_ready = 1'b1;
    step;
    step;
    n_tests++;
    if ({state, alusrc, alu_op} !== {3'd2, 1'b1, 2'b00}) begin
      n_fail++; $display("FAIL st_exec: got st=%0d alusrc=%b alu_op=%b expected st=2 alusrc=1 alu_op=00",
        state, alusrc, alu_op);
    end
    step;
    n_tests++;
    if ({state, mem_write, mem_read, reg_write} !== {3'd3, 1'b1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL st_mem: got st=%0d mw=%b mr=%b rw=%b expected st=3 mw=1 mr=0 rw=0",
        state, mem_write, mem_read, reg_write);
    end
    step;
    exp_ret = exp_ret + 4'd1;
    n_tests++;
    if ({state, retired} !== {3'd0, exp_ret}) begin
      n_fail++; $display("FAIL st_retire: got st=%0d ret=%0d expected st=0 ret=%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_load_wait;
    int  cyc = 0;
    int  memrd = 0;
    int  mem_cyc = 0;
    int  both = 0;
    bit  done = 1'b0;
    bit  wb_seen = 1'b0;
    bit  wb_m2r = 1'b0;
    opcode = 7'b0000011;
    for (int c = 0; c < 20 && !done; c++) begin
      // memory stalls for the first three MEM cycles
      mem_ready = !(state == 3'd3 && mem_cyc < 3);
      #1;
      cyc++;
      if (state == 3'd3) begin
        mem_cyc++;
        if (mem_read) memrd++;
      end
      if (mem_read && mem_write) both++;
      if (state == 3'd4) begin wb_seen = 1'b1; wb_m2r = mem_to_reg; end
      @(posedge clk);
      #1;
      if (state == 3'd0) done = 1'b1;
    end
    mem_ready = 1'b1;
    exp_ret = exp_ret + 4'd1;
    n_tests++; if (cyc != 8) begin n_fail++; $display("FAIL ld_latency: got %0d cycles expected 8", cyc); end
    n_tests++; if (memrd != 4) begin n_fail++; $display("FAIL ld_mem_read: got %0d cycles expected 4", memrd); end
    n_tests++; if (both != 0) begin n_fail++; $display("FAIL ld_rd_wr_overlap: got %0d cycles expected 0", both); end
    n_tests++;
    if ({wb_seen, wb_m2r} !== 2'b11) begin
      n_fail++; $display("FAIL ld_wb: got seen=%b m2r=%b expected seen=1 m2r=1", wb_seen, wb_m2r);
    end
    n_tests++; if (retired !== exp_ret) begin n_fail++; $display("FAIL ld_retire: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_branch;
    opcode = 7'b1100011; mem_ready = 1'b1; zero = 1'b1;
    step;
    step;
    n_tests++;
    if ({state, pc_write, pc_src, alu_op, alusrc} !== {3'd2, 1'b1, 1'b1, 2'b01, 1'b0}) begin
      n_fail++; $display("FAIL br_taken: got st=%0d pcw=%b pcs=%b alu_op=%b alusrc=%b expected st=2 pcw=1 pcs=1 alu_op=01 alusrc=0",
        state, pc_write, pc_src, alu_op, alusrc);
    end
    step;
    n_tests++; if (state !== 3'd0) begin n_fail++; $display("FAIL br_latency: got st=%0d expected 0", state); end
    zero = 1'b0;
    step;
    step;
    n_tests++;
    if ({state, pc_write, pc_src} !== {3'd2, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL br_not_taken: got st=%0d pcw=%b pcs=%b expected st=2 pcw=0 pcs=1", state, pc_write, pc_src);
    end
    step;
    exp_ret = exp_ret + 4'd2;
    n_tests++;
    if ({state, retired} !== {3'd0, exp_ret}) begin
      n_fail++; $display("FAIL br_retire: got st=%0d ret=%0d expected st=0 ret=%0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_reset_mid_store;
    opcode = 7'b0100011; mem_ready = 1'b1;
    step;
    step;
    mem_ready = 1'b0;
    step;
    n_tests++; if ({state, mem_write} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL rst_store_mem: got st=%0d mw=%b expected st=3 mw=1", state, mem_write);
    end
    rst_n = 1'b0;
    #1;
    n_tests++; if ({mem_write, mem_read} !== 2'b00) begin
      n_fail++; $display("FAIL rst_store_drop: got mw=%b mr=%b expected 00", mem_write, mem_read);
    end
    step;
    n_tests++; if ({state, retired, mem_write} !== {3'd0, 4'd0, 1'b0}) begin
      n_fail++; $display("FAIL rst_store_abandon: got st=%0d ret=%0d mw=%b expected st=0 ret=0 mw=0", state, retired, mem_write);
    end
    rst_n = 1'b1; mem_ready = 1'b1;
    exp_ret = 4'd0;
    #1;
    n_tests++; if ({state, mem_write, mem_read} !== {3'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rst_store_refetch: got st=%0d mw=%b mr=%b expected st=0 mw=0 mr=1", state, mem_write, mem_read);
    end
  endtask

  task automatic test_illegal;
    opcode = 7'b1111111; mem_ready = 1'b1;
    step;
    n_tests++; if ({state, pc_write, illegal_instr} !== {3'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL ill_decode: got st=%0d pcw=%b ill=%b expected st=1 pcw=0 ill=0", state, pc_write, illegal_instr);
    end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    begin
      int bad = 0;
      for (int c = 0; c < 10; c++) begin
        step;
        if (state !== 3'd5 || illegal_instr !== 1'b1 || mem_read !== 1'b0 || pc_write !== 1'b0) bad++;
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL ill_trap_hold: got %0d bad cycles expected 0", bad); end
      n_tests++; if (retired !== exp_ret) begin n_fail++; $display("FAIL ill_trap_retire: got %0d expected %0d", retired, exp_ret); end
      rst_n = 1'b0;
      step;
      rst_n = 1'b1;
      exp_ret = 4'd0;
    end
`else
    step;
    n_tests++;
    if ({state, retired, illegal_instr} !== {3'd0, exp_ret, 1'b0}) begin
      n_fail++; $display("FAIL ill_nop: got st=%0d ret=%0d ill=%b expected st=0 ret=%0d ill=0",
        state, retired, illegal_instr, exp_ret);
    end
`endif
  endtask

  task automatic test_wrap;
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    exp_ret = 4'd0;
    opcode = 7'b0110011; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat (4) step;
      if (i == 14) begin
        n_tests++; if (retired !== 4'd15) begin n_fail++; $display("FAIL wrap_pre: got %0d expected 15", retired); end
      end
    end
    n_tests++;
    if ({state, retired} !== {3'd0, 4'd0}) begin
      n_fail++; $display("FAIL wrap_zero: got st=%0d ret=%0d expected st=0 ret=0", state, retired);
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_store;
    test_load_wait;
    test_branch;
    test_reset_mid_store;
    test_illegal;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
